fetch_unit: RTL



---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers ROM words into the IR and handles
// jump/call/return with a return-address stack. Define FETCH_PERF_EN for fetch/bubble counters.
module fetch_unit #(
    parameter int WORD_WIDTH  = 24,
    parameter int ADDR_BITS   = 8,
    parameter int OP_BITS     = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ADDR_BITS-1:0]          rom_addr,
    input  logic [WORD_WIDTH-1:0]         rom_data,
    input  logic                          stall,
    input  logic                          jmp_en,
    input  logic                          cll_en,
    input  logic                          ret_en,
    input  logic [ADDR_BITS-1:0]          tgt_addr,
    input  logic                          halt,
    output logic [WORD_WIDTH-1:0]         ir,
    output logic [OP_BITS-1:0]            opcode,
    output logic [WORD_WIDTH-OP_BITS-1:0] operand,
    output logic [ADDR_BITS-1:0]          ir_pc,
    output logic                          ir_valid,
    output logic                          stack_err,
    output logic                          halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]                   fetch_cnt,
    output logic [15:0]                   bubble_cnt
`endif
);

    localparam int SP_BITS = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    pc_q, pc_d;
    logic [WORD_WIDTH-1:0]   ir_q, ir_d;
    logic [ADDR_BITS-1:0]    ir_pc_q, ir_pc_d;
    logic                    ir_valid_q, ir_valid_d;
    logic [SP_BITS-1:0]      sp_q, sp_d;
    logic                    err_q, err_d;
    logic [ADDR_BITS-1:0]    stack_q [STACK_DEPTH];
    logic                    push_en;
    logic [SP_BITS-1:0]      sp_dec;
    logic [SP_BITS-2:0]      top_idx;
    logic [ADDR_BITS-1:0]    ret_addr;

    assign sp_dec   = sp_q - SP_BITS'(1);
    assign top_idx  = sp_dec[SP_BITS-2:0];
    assign ret_addr = ir_pc_q + ADDR_BITS'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        sp_d       = sp_q;
        err_d      = err_q;
        push_en    = 1'b0;
        case (state_q)
            // ROM output is not meaningful in the first cycle after reset.
            S_BOOT: begin
                state_d    = S_RUN;
                ir_valid_d = 1'b0;
            end
            S_RUN: begin
                if (halt) begin
                    state_d    = S_HALT;
                    ir_valid_d = 1'b0;
                end else if (ret_en) begin
                    ir_valid_d = 1'b0;
                    if (sp_q != '0) begin
                        pc_d = stack_q[top_idx];
                        sp_d = sp_dec;
                    end else begin
                        pc_d  = '0;
                        err_d = 1'b1;
                    end
                end else if (cll_en) begin
                    ir_valid_d = 1'b0;
                    pc_d       = tgt_addr;
                    if (sp_q == SP_BITS'(STACK_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_BITS'(1);
                    end
                end else if (jmp_en) begin
                    ir_valid_d = 1'b0;
                    pc_d       = tgt_addr;
                end else if (!stall) begin
                    ir_d       = rom_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_BITS'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
        end
    end

    // Stack contents need no reset: the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            stack_q[sp_q[SP_BITS-2:0]] <= ret_addr;
        end
    end

    assign rom_addr  = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[WORD_WIDTH-1 -: OP_BITS];
    assign operand   = ir_q[WORD_WIDTH-OP_BITS-1:0];
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign stack_err = err_q;
    assign halted    = (state_q == S_HALT);

`ifdef FETCH_PERF_EN
    logic        fetch_inc, bubble_inc;
    logic [15:0] fetch_cnt_q, bubble_cnt_q;

    assign fetch_inc  = (state_q == S_RUN) && !halt && !ret_en && !cll_en && !jmp_en && !stall;
    assign bubble_inc = (state_q == S_RUN) && !halt && (ret_en || cll_en || jmp_en || stall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (fetch_inc && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (bubble_inc && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
